aes_block_loader: RTL and testbench

//  Byte-serial input front end for the AES datapath: the input-side counterpart of the byte-to-7-seg output path.

---
 rtl/aes_block_loader_if.sv | 26 ++
 rtl/aes_block_loader.sv | 143 ++++++++++++++
 tb/tb_aes_block_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_loader_if.sv
// Byte-stream input and assembled-block output bundle for aes_block_loader.
// The slave modport is the loader's view; the master modport is the byte source / block consumer.
interface aes_block_loader_if #(
   parameter int unsigned KEY_W = 256
);
   logic [1:0]       key_mode;
   logic             key_reuse;
   logic [7:0]       s_data;
   logic             s_valid;
   logic             s_ready;
   logic             m_valid;
   logic             m_ready;
   logic [KEY_W-1:0] m_key;
   logic [127:0]     m_data;
   logic [1:0]       m_mode;

   modport master (
      output key_mode, key_reuse, s_data, s_valid, m_ready,
      input  s_ready, m_valid, m_key, m_data, m_mode
   );

   modport slave (
      input  key_mode, key_reuse, s_data, s_valid, m_ready,
      output s_ready, m_valid, m_key, m_data, m_mode
   );
endinterface

// File: rtl/aes_block_loader.sv
// Byte-serial front end for the AES datapath: assembles a 128/192/256-bit key and a 128-bit
// data block from a valid/ready byte stream and presents {key, data, mode} downstream.
// A stored key can be reused so follow-on blocks need only 16 data bytes.
module aes_block_loader #(
   parameter int unsigned KEY_W = 256,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   aes_block_loader_if.slave bus,
   output logic             key_valid,
   output logic [CNT_W-1:0] blk_count
);

   typedef enum logic [1:0] {
      StIdle,
      StLoadKey,
      StLoadData,
      StPresent
   } state_e;

   state_e             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [KEY_W-1:0]   m_key_q, m_key_d;
   logic [127:0]       m_data_q, m_data_d;
   logic [1:0]         m_mode_q, m_mode_d;
   logic               m_valid_q, m_valid_d;
   logic               key_valid_q, key_valid_d;
   logic [CNT_W-1:0]   blk_count_q, blk_count_d;

   logic               s_ready;
   logic               byte_xfer;
   logic [4:0]         key_last;

   // s_ready is forced low for as long as reset is held.
   assign s_ready   = (state_q != StPresent) && !reset;
   assign byte_xfer = bus.s_valid && s_ready;

   // Index of the final key byte for the mode latched at the start of the frame.
   always_comb begin
      key_last = 5'd15;
      unique case (m_mode_q)
         2'b01:   key_last = 5'd23;
         2'b10:   key_last = 5'd31;
         default: key_last = 5'd15;
      endcase
   end

   // Next-state logic for the frame assembly FSM and its registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      m_key_d     = m_key_q;
      m_data_d    = m_data_q;
      m_mode_d    = m_mode_q;
      m_valid_d   = m_valid_q;
      key_valid_d = key_valid_q;
      blk_count_d = blk_count_q;

      unique case (state_q)
         StIdle: begin
            if (byte_xfer) begin
               // Mode 11 is an alias of 128-bit and is reported as 00.
               m_mode_d = (bus.key_mode == 2'b11) ? 2'b00 : bus.key_mode;
               cnt_d    = 5'd1;
               if (bus.key_reuse && key_valid_q) begin
                  m_data_d = {m_data_q[119:0], bus.s_data};
                  state_d  = StLoadData;
               end else begin
                  // Clearing on the first key byte leaves shorter keys right-aligned.
                  m_key_d     = {{(KEY_W-8){1'b0}}, bus.s_data};
                  key_valid_d = 1'b0;
                  state_d     = StLoadKey;
               end
            end
         end
         StLoadKey: begin
            if (byte_xfer) begin
               m_key_d = {m_key_q[KEY_W-9:0], bus.s_data};
               if (cnt_q == key_last) begin
                  key_valid_d = 1'b1;
                  cnt_d       = 5'd0;
                  state_d     = StLoadData;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         StLoadData: begin
            if (byte_xfer) begin
               m_data_d = {m_data_q[119:0], bus.s_data};
               if (cnt_q == 5'd15) begin
                  cnt_d     = 5'd0;
                  m_valid_d = 1'b1;
                  state_d   = StPresent;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         StPresent: begin
            if (bus.m_ready) begin
               m_valid_d   = 1'b0;
               blk_count_d = blk_count_q + 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         m_key_q     <= '0;
         m_data_q    <= '0;
         m_mode_q    <= '0;
         m_valid_q   <= 1'b0;
         key_valid_q <= 1'b0;
         blk_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         m_key_q     <= m_key_d;
         m_data_q    <= m_data_d;
         m_mode_q    <= m_mode_d;
         m_valid_q   <= m_valid_d;
         key_valid_q <= key_valid_d;
         blk_count_q <= blk_count_d;
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid_q;
   assign bus.m_key   = m_key_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_mode  = m_mode_q;
   assign key_valid   = key_valid_q;
   assign blk_count   = blk_count_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: frames are modelled on send, expected blocks are queued
// and compared when the loader presents them.
module tb_aes_block_loader;

   typedef struct packed {
      logic [255:0] key;
      logic [127:0] data;
      logic [1:0]   mode;
   } blk_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_valid;
   logic [7:0] blk_count;

   aes_block_loader_if bus ();

   aes_block_loader dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .key_valid (key_valid),
      .blk_count (blk_count)
   );

   always #5 clk = ~clk;

   int           total = 0;
   int           bad = 0;
   blk_t         sb[$];
   logic [7:0]   exp_blk = '0;
   bit           mdl_kv = 1'b0;
   logic [255:0] mdl_key = '0;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte and hold it until the loader accepts it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      while (bus.s_ready !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("s_ready_wait", 256'(bus.s_ready), 256'd1);
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic maybe_gap(input int gap_pct);
      if ($urandom_range(0, 99) < gap_pct) begin
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame and queue the block the loader should present for it.
   task automatic send_frame(input logic [1:0] mode, input bit reuse, input logic [7:0] kbase,
                             input logic [7:0] dbase, input logic [7:0] dstep,
                             input int gap_pct, input bit toggle);
      logic [1:0]   mm;
      int           kb;
      bit           full;
      logic [127:0] d;
      logic [7:0]   b;
      blk_t         e;
      mm   = (mode == 2'b11) ? 2'b00 : mode;
      kb   = (mm == 2'b01) ? 24 : (mm == 2'b10) ? 32 : 16;
      full = !(reuse && mdl_kv);
      d    = '0;
      for (int i = 0; i < 16; i++) begin
         b = 8'(dbase + dstep * 8'(i));
         d = {d[119:0], b};
      end
      if (full) begin
         mdl_key = '0;
         for (int i = 0; i < kb; i++) begin
            b       = 8'(kbase + 8'(i));
            mdl_key = {mdl_key[247:0], b};
         end
      end
      e.key  = mdl_key;
      e.data = d;
      e.mode = mm;
      sb.push_back(e);

      bus.key_mode  = mode;
      bus.key_reuse = reuse;
      if (full) begin
         for (int i = 0; i < kb; i++) begin
            if (i > 0) maybe_gap(gap_pct);
            send_byte(8'(kbase + 8'(i)));
            if (i == 0) begin
               check("key_valid_cleared", 256'(key_valid), 256'd0);
               if (toggle) begin
                  bus.key_mode  = 2'($urandom_range(0, 3));
                  bus.key_reuse = 1'($urandom_range(0, 1));
               end
            end
         end
         check("key_valid_set", 256'(key_valid), 256'd1);
      end
      for (int i = 0; i < 16; i++) begin
         if (i > 0 || full) maybe_gap(gap_pct);
         send_byte(8'(dbase + dstep * 8'(i)));
         if (i == 0 && !full && toggle) begin
            bus.key_mode  = 2'($urandom_range(0, 3));
            bus.key_reuse = 1'($urandom_range(0, 1));
         end
      end
      mdl_kv = 1'b1;
      // The block becomes visible one cycle after the final byte.
      check("m_valid_latency", 256'(bus.m_valid), 256'd1);
   endtask

   // Wait for a block, optionally stall it, then accept it and compare against the queue.
   task automatic recv_block(input int hold);
      int   n;
      blk_t e;
      n = 0;
      while (bus.m_valid !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("m_valid_wait", 256'(bus.m_valid), 256'd1);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL sb_empty: got a block, expected none queued");
         return;
      end
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("hold_m_valid", 256'(bus.m_valid), 256'd1);
         check("hold_s_ready", 256'(bus.s_ready), 256'd0);
         check("hold_m_key", bus.m_key, e.key);
         check("hold_m_data", 256'(bus.m_data), 256'(e.data));
         @(posedge clk);
         #1;
      end
      check("m_key", bus.m_key, e.key);
      check("m_data", 256'(bus.m_data), 256'(e.data));
      check("m_mode", 256'(bus.m_mode), 256'(e.mode));
      bus.m_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.m_ready = 1'b0;
      exp_blk++;
      check("blk_count", 256'(blk_count), 256'(exp_blk));
      check("m_valid_drop", 256'(bus.m_valid), 256'd0);
      check("s_ready_back", 256'(bus.s_ready), 256'd1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.m_ready   = 1'b0;
      bus.key_mode  = '0;
      bus.key_reuse = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 256'(bus.s_ready), 256'd0);
      check("rst_m_valid", 256'(bus.m_valid), 256'd0);
      check("rst_m_key", bus.m_key, 256'd0);
      check("rst_m_data", 256'(bus.m_data), 256'd0);
      check("rst_m_mode", 256'(bus.m_mode), 256'd0);
      check("rst_key_valid", 256'(key_valid), 256'd0);
      check("rst_blk_count", 256'(blk_count), 256'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_s_ready", 256'(bus.s_ready), 256'd1);

      // m_ready with nothing presented must not count a block.
      bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.m_ready = 1'b0;
      check("idle_m_ready", 256'(blk_count), 256'd0);

      // T1: 128-bit key.
      send_frame(2'b00, 1'b0, 8'h00, 8'h00, 8'h11, 0, 1'b0);
      check("t1_key", bus.m_key, 256'h000102030405060708090a0b0c0d0e0f);
      check("t1_data", 256'(bus.m_data), 256'h00112233445566778899aabbccddeeff);
      recv_block(0);

      // T4: reuse the 128-bit key with 16 data bytes only.
      send_frame(2'b00, 1'b1, 8'h00, 8'hff, 8'hff, 0, 1'b0);
      check("t4_key", bus.m_key, 256'h000102030405060708090a0b0c0d0e0f);
      check("t4_data", 256'(bus.m_data), 256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
      recv_block(0);
      check("t4_blk_count", 256'(blk_count), 256'd2);

      // T2: 192-bit key.
      send_frame(2'b01, 1'b0, 8'h00, 8'h40, 8'h01, 0, 1'b0);
      check("t2_key", bus.m_key, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
      check("t2_mode", 256'(bus.m_mode), 256'd1);
      recv_block(0);

      // T3: 256-bit key with the consumer stalling for 5 cycles.
      send_frame(2'b10, 1'b0, 8'h00, 8'h80, 8'h03, 0, 1'b0);
      recv_block(5);

      // Mode 11 behaves as 128-bit and reports 00.
      send_frame(2'b11, 1'b0, 8'h20, 8'h10, 8'h05, 0, 1'b0);
      recv_block(1);

      // T5: reset in the middle of a key phase.
      bus.key_mode  = 2'b10;
      bus.key_reuse = 1'b0;
      for (int i = 0; i < 10; i++) send_byte(8'(i));
      #2;
      reset = 1'b1;
      #1;
      check("t5_s_ready", 256'(bus.s_ready), 256'd0);
      check("t5_m_valid", 256'(bus.m_valid), 256'd0);
      check("t5_key_valid", 256'(key_valid), 256'd0);
      check("t5_m_key", bus.m_key, 256'd0);
      check("t5_blk_count", 256'(blk_count), 256'd0);
      @(negedge clk);
      reset   = 1'b0;
      mdl_kv  = 1'b0;
      exp_blk = '0;
      @(posedge clk);
      #1;
      // Reuse requested without a stored key still consumes a full key phase.
      send_frame(2'b00, 1'b1, 8'h00, 8'h00, 8'h11, 0, 1'b0);
      recv_block(0);

      // T6: random gaps and inputs toggled after the first byte of each frame.
      send_frame(2'b10, 1'b0, 8'h00, 8'h80, 8'h03, 40, 1'b1);
      recv_block(2);
      send_frame(2'b01, 1'b0, 8'h30, 8'h55, 8'h07, 40, 1'b1);
      recv_block(0);
      send_frame(2'b00, 1'b0, 8'h90, 8'h01, 8'h02, 40, 1'b1);
      recv_block(0);
      do begin
         send_frame(2'($urandom_range(0, 3)), 1'b1, 8'h00, 8'($urandom), 8'($urandom), 10, 1'b1);
         recv_block(0);
      end while (exp_blk != 8'd0);
      check("t6_blk_wrap", 256'(blk_count), 256'd0);
      check("t6_key_kept", bus.m_key, mdl_key);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
